// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and the 16-bit op sequencer that reuses it.
package alu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_ADC  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_SBC  = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_OR   = 5'd6;
  localparam logic [4:0] ALU_CP   = 5'd7;
  localparam logic [4:0] ALU_INC  = 5'd8;
  localparam logic [4:0] ALU_DEC  = 5'd9;
  localparam logic [4:0] ALU_RLC  = 5'd10;
  localparam logic [4:0] ALU_RRC  = 5'd11;
  localparam logic [4:0] ALU_RL   = 5'd12;
  localparam logic [4:0] ALU_RR   = 5'd13;
  localparam logic [4:0] ALU_SLA  = 5'd14;
  localparam logic [4:0] ALU_SRA  = 5'd15;
  localparam logic [4:0] ALU_SWAP = 5'd16;
  localparam logic [4:0] ALU_SRL  = 5'd17;
  localparam logic [4:0] ALU_BIT  = 5'd18;
  localparam logic [4:0] ALU_RES  = 5'd19;
  localparam logic [4:0] ALU_SET  = 5'd20;

  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;

  localparam logic [7:0] F_Z  = 8'h80;
  localparam logic [7:0] F_C  = 8'h10;
  localparam logic [7:0] F_HC = 8'h30;

  typedef enum logic [1:0] {OP16_ADD, OP16_ADD_SP, OP16_INC, OP16_DEC} op16_e;
  typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_DONE} seq_state_e;

endpackage

// File: rtl/alu8.sv
// SM83 8-bit ALU, purely combinational. BIT/RES/SET take the bit index from regB[2:0].
module alu8
  import alu_pkg::*;
(
  input  logic [7:0] regA,
  input  logic [7:0] regB,
  input  logic [4:0] opcode,
  input  logic [7:0] flagsIn,
  output logic [7:0] res,
  output logic [7:0] flagsOut
);
  logic       cin;
  logic [8:0] wide;
  logic [4:0] nib;
  logic [7:0] mask;

  always_comb begin
    res      = regA;
    flagsOut = flagsIn;
    cin      = ((opcode == ALU_ADC) || (opcode == ALU_SBC)) && flagsIn[FLAG_C];
    wide     = '0;
    nib      = '0;
    mask     = 8'h01 << regB[2:0];
    case (opcode)
      ALU_ADD, ALU_ADC: begin
        wide = {1'b0, regA} + {1'b0, regB} + {8'b0, cin};
        nib  = {1'b0, regA[3:0]} + {1'b0, regB[3:0]} + {4'b0, cin};
        res  = wide[7:0];
        flagsOut[7:4] = {wide[7:0] == 8'h00, 1'b0, nib[4], wide[8]};
      end
      ALU_SUB, ALU_SBC, ALU_CP: begin
        wide = {1'b0, regA} - {1'b0, regB} - {8'b0, cin};
        nib  = {1'b0, regA[3:0]} - {1'b0, regB[3:0]} - {4'b0, cin};
        if (opcode != ALU_CP) res = wide[7:0];
        flagsOut[7:4] = {wide[7:0] == 8'h00, 1'b1, nib[4], wide[8]};
      end
      ALU_AND: begin res = regA & regB; flagsOut[7:4] = {res == 8'h00, 3'b010}; end
      ALU_XOR: begin res = regA ^ regB; flagsOut[7:4] = {res == 8'h00, 3'b000}; end
      ALU_OR:  begin res = regA | regB; flagsOut[7:4] = {res == 8'h00, 3'b000}; end
      ALU_INC: begin
        res = regA + 8'h01;
        flagsOut[7:5] = {res == 8'h00, 1'b0, regA[3:0] == 4'hF};
      end
      ALU_DEC: begin
        res = regA - 8'h01;
        flagsOut[7:5] = {res == 8'h00, 1'b1, regA[3:0] == 4'h0};
      end
      ALU_RLC:  begin res = {regA[6:0], regA[7]};          flagsOut[7:4] = {res == 8'h00, 2'b00, regA[7]}; end
      ALU_RRC:  begin res = {regA[0], regA[7:1]};          flagsOut[7:4] = {res == 8'h00, 2'b00, regA[0]}; end
      ALU_RL:   begin res = {regA[6:0], flagsIn[FLAG_C]};  flagsOut[7:4] = {res == 8'h00, 2'b00, regA[7]}; end
      ALU_RR:   begin res = {flagsIn[FLAG_C], regA[7:1]};  flagsOut[7:4] = {res == 8'h00, 2'b00, regA[0]}; end
      ALU_SLA:  begin res = {regA[6:0], 1'b0};             flagsOut[7:4] = {res == 8'h00, 2'b00, regA[7]}; end
      ALU_SRA:  begin res = {regA[7], regA[7:1]};          flagsOut[7:4] = {res == 8'h00, 2'b00, regA[0]}; end
      ALU_SWAP: begin res = {regA[3:0], regA[7:4]};        flagsOut[7:4] = {res == 8'h00, 3'b000}; end
      ALU_SRL:  begin res = {1'b0, regA[7:1]};             flagsOut[7:4] = {res == 8'h00, 2'b00, regA[0]}; end
      ALU_BIT:  flagsOut[7:5] = {(regA & mask) == 8'h00, 2'b01};
      ALU_RES:  res = regA & ~mask;
      ALU_SET:  res = regA | mask;
      default: ;
    endcase
  end
endmodule

// File: rtl/alu16_seq.sv
// Runs a 16-bit SM83 op as two passes through the shared alu8 (low byte, then high byte
// with the low carry chained in) and merges the pass flags into the architectural F.
module alu16_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opA,
  input  logic [15:0] opB,
  input  logic [7:0]  flagsIn,
  output logic [7:0]  alu_regA,
  output logic [7:0]  alu_regB,
  output logic [4:0]  alu_opcode,
  output logic [7:0]  alu_flagsIn,
  input  logic [7:0]  alu_res,
  input  logic [7:0]  alu_flagsOut,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [7:0]  flagsOut
);
  seq_state_e  st, st_nxt;
  op16_e       op_q;
  logic [15:0] a_q, b_q;
  logic [7:0]  f_q, lo_res, lo_f, f_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) st <= ST_IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE: if (start) st_nxt = ST_LO;
      ST_LO:   st_nxt = ST_HI;
      ST_HI:   st_nxt = ST_DONE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_regA    = '0;
    alu_regB    = '0;
    alu_opcode  = ALU_ADD;
    alu_flagsIn = '0;
    busy        = (st != ST_IDLE);
    done        = (st == ST_DONE);
    case (st)
      ST_LO: begin
        alu_regA   = a_q[7:0];
        alu_regB   = (op_q == OP16_INC || op_q == OP16_DEC) ? 8'h01 : b_q[7:0];
        alu_opcode = (op_q == OP16_DEC) ? ALU_SUB : ALU_ADD;
      end
      ST_HI: begin
        alu_regA    = a_q[15:8];
        alu_flagsIn = lo_f & F_C;
        alu_opcode  = (op_q == OP16_DEC) ? ALU_SBC : ALU_ADC;
        case (op_q)
          OP16_ADD:    alu_regB = b_q[15:8];
          OP16_ADD_SP: alu_regB = {8{b_q[7]}};
          default:     alu_regB = 8'h00;
        endcase
      end
      default: ;
    endcase
  end

  // ADD HL keeps Z and takes H/C from the high pass; ADD SP reports the low-byte carries.
  always_comb begin
    case (op_q)
      OP16_ADD:    f_nxt = (f_q & F_Z) | (alu_flagsOut & F_HC);
      OP16_ADD_SP: f_nxt = lo_f & F_HC;
      default:     f_nxt = f_q & 8'hF0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= OP16_ADD;
      a_q      <= '0;
      b_q      <= '0;
      f_q      <= '0;
      lo_res   <= '0;
      lo_f     <= '0;
      result   <= '0;
      flagsOut <= '0;
    end else begin
      case (st)
        ST_IDLE: if (start) begin
          op_q <= op16_e'(op);
          a_q  <= opA;
          b_q  <= opB;
          f_q  <= flagsIn;
        end
        ST_LO: begin
          lo_res <= alu_res;
          lo_f   <= alu_flagsOut;
        end
        ST_HI: begin
          result   <= {alu_res, lo_res};
          flagsOut <= f_nxt;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu16_seq.sv
// Bench for alu16_seq wired to alu8, checked against an arithmetic model of the 16-bit ops.
module tb_alu16_seq;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [1:0]  op;
  logic [15:0] opA, opB;
  logic [7:0]  flagsIn;
  logic [7:0]  alu_regA, alu_regB, alu_flagsIn, alu_res, alu_flagsOut;
  logic [4:0]  alu_opcode;
  logic        busy, done;
  logic [15:0] result;
  logic [7:0]  flagsOut;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu16_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opA(opA), .opB(opB), .flagsIn(flagsIn),
    .alu_regA(alu_regA), .alu_regB(alu_regB), .alu_opcode(alu_opcode), .alu_flagsIn(alu_flagsIn),
    .alu_res(alu_res), .alu_flagsOut(alu_flagsOut), .busy(busy), .done(done),
    .result(result), .flagsOut(flagsOut)
  );

  alu8 u_alu (
    .regA(alu_regA), .regB(alu_regB), .opcode(alu_opcode), .flagsIn(alu_flagsIn),
    .res(alu_res), .flagsOut(alu_flagsOut)
  );

  // Returns {result, F} for one 16-bit op, from whole-number arithmetic.
  function automatic logic [23:0] model(input logic [1:0] o, input logic [15:0] a, b,
                                        input logic [7:0] f);
    int sa, sb, e;
    logic [15:0] r;
    logic [7:0]  fo;
    sa = int'(a);
    sb = int'(b);
    e  = (b[7:0] >= 8'd128) ? int'(b[7:0]) - 256 : int'(b[7:0]);
    case (o)
      2'd0: begin
        r  = 16'(sa + sb);
        fo = {f[7], 1'b0, ((sa % 4096) + (sb % 4096)) > 4095, (sa + sb) > 65535, 4'b0};
      end
      2'd1: begin
        r  = 16'(sa + e);
        fo = {2'b00, ((sa % 16) + int'(b[3:0])) > 15, ((sa % 256) + int'(b[7:0])) > 255, 4'b0};
      end
      2'd2:    begin r = 16'(sa + 1); fo = f; end
      default: begin r = 16'(sa - 1); fo = f; end
    endcase
    return {r, fo};
  endfunction

  // Issues one op and waits (bounded) for done; lat is -1 if done never came.
  task automatic do_op(input logic [1:0] o, input logic [15:0] a, b, input logic [7:0] f,
                       output logic [15:0] r, output logic [7:0] fl, output int lat);
    @(negedge clk);
    op = o; opA = a; opB = b; flagsIn = f; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) lat = k;
    end
    r = result;
    fl = flagsOut;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'd0; opA = '0; opB = '0; flagsIn = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++; $display("FAIL reset_ctrl: busy/done=%b expected 00", {busy, done});
    end
    checks++;
    if ({result, flagsOut} !== 24'h0) begin
      failures++; $display("FAIL reset_regs: result/flags=%h expected 000000", {result, flagsOut});
    end
    checks++;
    if ({alu_regA, alu_regB, alu_opcode, alu_flagsIn} !== 29'h0) begin
      failures++; $display("FAIL reset_port: alu port=%h expected 0",
                           {alu_regA, alu_regB, alu_opcode, alu_flagsIn});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [1:0]  vo [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
    logic [15:0] va [6] = '{16'h0FFF, 16'hFFFF, 16'hFFF8, 16'h1000, 16'h00FF, 16'h0000};
    logic [15:0] vb [6] = '{16'h0001, 16'h0001, 16'h0008, 16'h00FF, 16'h0000, 16'h0000};
    logic [7:0]  vf [6] = '{8'h80, 8'h00, 8'h00, 8'hF0, 8'hF0, 8'h50};
    logic [15:0] er [6] = '{16'h1000, 16'h0000, 16'h0000, 16'h0FFF, 16'h0100, 16'hFFFF};
    logic [7:0]  ef [6] = '{8'hA0, 8'h30, 8'h30, 8'h00, 8'hF0, 8'h50};
    logic [15:0] r;
    logic [7:0]  fl;
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(vo[i], va[i], vb[i], vf[i], r, fl, lat);
      checks++;
      if (lat !== 2) begin
        failures++; $display("FAIL dir%0d_latency: done after %0d edges expected 2", i, lat);
      end
      checks++;
      if ({r, fl} !== {er[i], ef[i]}) begin
        failures++; $display("FAIL dir%0d_value: got %h/%h expected %h/%h", i, r, fl, er[i], ef[i]);
      end
      checks++;
      if ({busy, done} !== 2'b00) begin
        failures++; $display("FAIL dir%0d_pulse: busy/done=%b expected 00 after done", i, {busy, done});
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, r;
    logic [7:0]  f, fl;
    logic [1:0]  o;
    logic [23:0] exp;
    int lat;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = (i % 8 == 0) ? 16'hFFFF : ((i % 8 == 1) ? 16'h0000 : 16'($urandom));
      b = 16'($urandom);
      f = {4'($urandom), 4'b0};
      exp = model(o, a, b, f);
      do_op(o, a, b, f, r, fl, lat);
      checks++;
      if (lat !== 2 || {r, fl} !== exp) begin
        failures++;
        $display("FAIL rand%0d op=%0d a=%h b=%h f=%h: got %h/%h lat=%0d expected %h/%h lat=2",
                 i, o, a, b, f, r, fl, lat, exp[23:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [23:0] exp;
    int ndone;
    exp = model(2'd0, 16'h1234, 16'h1111, 8'h00);
    @(negedge clk);
    op = 2'd0; opA = 16'h1234; opB = 16'h1111; flagsIn = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    op = 2'd3; opA = 16'h0000; opB = 16'hBEEF; flagsIn = 8'hF0;
    checks++;
    if ({busy, done} !== 2'b10) begin
      failures++; $display("FAIL ign_lo_state: busy/done=%b expected 10", {busy, done});
    end
    ndone = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    start = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 1) begin
      failures++; $display("FAIL ign_pulses: saw %0d done pulses expected 1", ndone);
    end
    checks++;
    if ({result, flagsOut} !== exp) begin
      failures++; $display("FAIL ign_value: got %h/%h expected %h/%h", result, flagsOut, exp[23:8], exp[7:0]);
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] r;
    logic [7:0]  fl;
    int lat, ndone;
    @(negedge clk);
    op = 2'd0; opA = 16'h4000; opB = 16'h4000; flagsIn = 8'h80; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, result, flagsOut} !== 26'h0) begin
      failures++; $display("FAIL abort_state: busy/done/result/flags=%b/%b/%h/%h expected all 0",
                           busy, done, result, flagsOut);
    end
    rst_n = 1'b1;
    ndone = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++; $display("FAIL abort_pulse: saw %0d done pulses expected 0", ndone);
    end
    do_op(2'd2, 16'h1234, 16'h0000, 8'h30, r, fl, lat);
    checks++;
    if (lat !== 2 || {r, fl} !== {16'h1235, 8'h30}) begin
      failures++; $display("FAIL abort_recover: got %h/%h lat=%0d expected 1235/30 lat=2", r, fl, lat);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu16_seq.md
Name: alu16_seq

Overview:
Sequencer that performs the SM83 16-bit arithmetic ops (ADD HL,rr / ADD SP,e8 / INC rr / DEC rr) by running the shared 8-bit ALU twice, low byte then high byte. It sits between CPU decode and the alu8 instance and drives alu8's inputs through a master port. The CPU-top mux selects this port while busy=1. It merges the two passes' flags into the architecturally correct F value.

Parameters:
none (data width fixed at 16, ALU width fixed at 8)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
start  in  1  request; accepted only in IDLE
op  in  2  0=ADD16, 1=ADD_SP_E8, 2=INC16, 3=DEC16
opA  in  16  first operand (HL / SP / rr)
opB  in  16  second operand; ADD_SP_E8 uses opB[7:0] as signed e8; ignored for INC16/DEC16
flagsIn  in  8  current F (Z7 N6 H5 C4, [3:0]=0)
alu_regA  out  8  to alu8 regA
alu_regB  out  8  to alu8 regB
alu_opcode  out  5  to alu8 opcode
alu_flagsIn  out  8  to alu8 flagsIn
alu_res  in  8  from alu8 res (combinational)
alu_flagsOut  in  8  from alu8 flagsOut
busy  out  1  high in LO, HI, DONE
done  out  1  one-cycle pulse; result/flagsOut valid
result  out  16  registered result, held until next accepted start
flagsOut  out  8  registered new F, held likewise

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, result=0, flagsOut=0, done=0, busy=0, and all latched operands cleared. Reset overrides any in-flight op. No pulse is produced for an aborted op.
- FSM states: IDLE -> LO -> HI -> DONE -> IDLE.
  - IDLE: transition on start=1. Latch op, opA, opB and flagsIn.
  - LO and HI: each takes one cycle. DONE also takes one cycle.
- Latency: start sampled at edge N. done=1 during cycle N+3. Next start is accepted in IDLE at edge N+4 at the earliest.
- start while busy=1: ignored; latched inputs do not change.
- IDLE alu port drive: alu_regA=0, alu_regB=0, alu_opcode=ADD (00000), alu_flagsIn=0.
- LO pass: alu_regA=opA[7:0]. At the LO->HI edge, capture alu_res into a low-byte register and alu_flagsOut into a low-flags register.
  - ADD16: opcode ADD, regB=opB[7:0].
  - ADD_SP_E8: opcode ADD, regB=opB[7:0].
  - INC16: opcode ADD, regB=0x01.
  - DEC16: opcode SUB (00010), regB=0x01.
- HI pass: alu_regA=opA[15:8]; alu_flagsIn={3'b0, lowflags[4], 4'b0}. At the HI->DONE edge, result={alu_res, lowbyte}.
  - ADD16: opcode ADC (00001), regB=opB[15:8].
  - ADD_SP_E8: opcode ADC, regB={8{opB[7]}} (sign extension).
  - INC16: opcode ADC, regB=0x00.
  - DEC16: opcode SBC (00011), regB=0x00.
- flagsOut, registered on the HI->DONE edge; bits [3:0] are always 0:
  - ADD16: Z=flagsIn.Z, N=0, H=HI-pass H (carry out of bit 11), C=HI-pass C (carry out of bit 15).
  - ADD_SP_E8: Z=0, N=0, H=LO-pass H, C=LO-pass C.
  - INC16/DEC16: flagsOut=flagsIn (flags unaffected).
- Arithmetic is modulo 2^16; wrap-around is silent (FFFF+1=0000, 0000-1=FFFF).
- The block never combinationally loops alu_res back into alu inputs within a cycle.

Decomposition:
- Shared package alu_pkg holds:
  - alu8 opcode constants (ADD..SET, 5-bit).
  - Flag bit indices FLAG_Z=7, FLAG_N=6, FLAG_H=5, FLAG_C=4.
  - 2-bit seq op enum (OP16_ADD, OP16_ADD_SP, OP16_INC, OP16_DEC).
  - FSM state enum.
- No sub-module. alu8 is instantiated at CPU top and muxed onto this port, so it stays shared with 8-bit ops.
- The bench instantiates alu8 plus alu16_seq together.

Test Plan:
- ADD16 opA=0x0FFF, opB=0x0001, flagsIn=0x80 -> done at N+3, result=0x1000, flagsOut=0xA0 (Z kept, H=1, C=0).
- ADD16 opA=0xFFFF, opB=0x0001, flagsIn=0x00 -> result=0x0000, flagsOut=0x30.
- ADD_SP_E8 opA=0xFFF8, opB[7:0]=0x08 -> result=0x0000, flagsOut=0x30. Repeat with opA=0x1000, e8=0xFF -> result=0x0FFF, flagsOut=0x00.
- INC16 opA=0x00FF, flagsIn=0xF0 -> result=0x0100, flagsOut=0xF0. DEC16 opA=0x0000, flagsIn=0x50 -> result=0xFFFF, flagsOut=0x50.
- start pulsed in LO and in HI with different operands -> ignored; result matches first op; exactly one done pulse.
- rst_n=0 during HI -> next cycle state IDLE, busy=0, done=0, result=0x0000, flagsOut=0x00. No done for the aborted op. A fresh start afterwards completes normally.
